// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - round-robin owner arbiter and registered word path for the shared internal bus
module rr_bus_arbiter #(
    parameter int DATA_W   = 18,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        req_i,
    input  logic [3:0]        done_i,
    input  logic [DATA_W-1:0] in0_i,
    input  logic [DATA_W-1:0] in1_i,
    input  logic [DATA_W-1:0] in2_i,
    input  logic [DATA_W-1:0] in3_i,
    output logic [3:0]        grant_o,
    output logic [1:0]        sel_o,
    output logic [DATA_W-1:0] bus_out_o,
    output logic              bus_valid_o,
    output logic              timeout_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;

    logic [1:0]        win;
    logic [1:0]        cand;
    logic              found;
    logic              own_req;
    logic              own_done;
    logic              limit_hit;
    logic              release_own;
    logic [DATA_W-1:0] sel_word;

    // Search starts just past the last owner so every requester gets a turn.
    always_comb begin
        win   = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign own_req     = req_i[sel_q];
    assign own_done    = done_i[sel_q];
    assign limit_hit   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign release_own = own_done || !own_req || limit_hit;

    always_comb begin
        case (sel_q)
            2'd0:    sel_word = in0_i;
            2'd1:    sel_word = in1_i;
            2'd2:    sel_word = in2_i;
            default: sel_word = in3_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)       state_d = GRANT;
            GRANT:   if (release_own) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    ptr_d   = win;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                hold_d = (hold_q == CNT_MAX) ? hold_q : hold_q + CNT_W'(1);
                if (release_own) begin
                    grant_d   = 4'b0000;
                    // A timeout is reported only when the limit alone forced the release.
                    timeout_d = limit_hit && !own_done && own_req;
                end
            end
            default: ;
        endcase
        bus_d   = (grant_q != 4'b0000) ? sel_word : bus_q;
        valid_d = (grant_q != 4'b0000);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd3;
            hold_q    <= '0;
            bus_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            bus_q     <= bus_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o     = grant_q;
    assign sel_o       = sel_q;
    assign bus_out_o   = bus_q;
    assign bus_valid_o = valid_q;
    assign timeout_o   = timeout_q;

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin arbiter that shares the processor's 18-bit internal bus among four requesters (register file, ALU, memory port, I/O port) by sequencing the select input of the 4-to-1 datapath multiplexer. It grants one requester at a time, drives `sel` to that requester's index, registers the selected word onto the bus, and reclaims the bus on release or after a bounded hold time. It sits between the requester control logic and the bus mux/latch in the datapath.

## Interface
- `DATA_W`, 18, bus word width
- `MAX_HOLD`, 8, maximum consecutive cycles one owner may hold the bus; 0 = unlimited
- `clk`  input  1  rising-edge clock, the only clock
- `rst`  input  1  reset, synchronous and active-high
- `req`  input  4  per-requester bus request, level
- `done`  input  4  per-requester release strobe; only the owner's bit is honoured
- `in0`..`in3`  input  DATA_W each  requester data words
- `grant`  output  4  one-hot owner, registered
- `sel`  output  2  mux select = owner index, registered
- `bus_out`  output  DATA_W  registered bus word
- `bus_valid`  output  1  `bus_out` carries owner data
- `timeout`  output  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT. Reset → IDLE.
- Reset values: `grant`=0, `sel`=0, `bus_out`=0, `bus_valid`=0, `timeout`=0, hold counter=0, last-owner pointer `ptr`=3, so requester 0 has top priority first.
- IDLE: if `req`≠0, pick the first set bit in order ptr+1, ptr+2, ptr+3, ptr (mod 4). Then set `grant`/`sel` to the winner, `ptr`←winner, clear the hold counter, and go to GRANT. If `req`=0, stay in IDLE.
- GRANT: hold counter increments each cycle. Release when any of these holds:
  - `done[owner]`=1;
  - `req[owner]`=0;
  - `MAX_HOLD`≠0 and counter = `MAX_HOLD`−1.
- On release, next edge: `grant`←0, go to IDLE. `sel` holds its last value.
- `timeout`=1 for one cycle only when release is caused solely by the hold limit. If `done` or a `req` drop coincides with the limit, there is no timeout.
- `done`/`req` on non-owner bits are ignored during GRANT. Non-owner requests stay pending and are not latched; a request withdrawn before arbitration is never granted.
- Data path, every edge: `bus_out`←in[`sel`] when `grant`≠0, else hold. `bus_valid`←(`grant`≠0).
- Counter width: $clog2(MAX_HOLD+1), minimum 1. It saturates when unused (`MAX_HOLD`=0).
- `rst` mid-grant: all outputs and `ptr` return to reset values on that edge, with no `timeout` pulse.

## Timing
- `req` high before edge N (arbiter in IDLE): `grant`/`sel` valid after edge N.
- `bus_out` = in[owner] sampled at edge N+1, with `bus_valid`=1 after edge N+1 (one-cycle lag behind `grant`).
- Release condition true before edge M: `grant`=0 after edge M, `bus_valid`=0 after edge M+1.
- Handover: there is always exactly one IDLE cycle between consecutive grants. Minimum grant period is 2 cycles, and the earliest next grant is after edge M+1.
- `timeout` is asserted in the cycle after edge M.
- With `MAX_HOLD`=K and the owner never releasing, `grant` is high for exactly K cycles.

## Test plan
- Reset: hold `rst` for 2 cycles with `req`=4'b1111 → all outputs 0. First grant after deassertion is `grant`=4'b0001, `sel`=0.
- Single requester: `req`=4'b0100, `in2`=18'h2A5A5, `done[2]` pulsed on the 4th grant cycle → `grant`=4'b0100 for 4 cycles. `bus_out`=18'h2A5A5 with `bus_valid` lagging by 1 cycle. No `timeout`.
- Round-robin fairness: `req`=4'b1111 held, each owner pulses `done` after 2 cycles → grant order 0,1,2,3,0. There is one idle cycle between grants.
- Hold limit: `MAX_HOLD`=8, `req`=4'b0011, owner 0 never releases → `grant[0]` high for 8 cycles, then a `timeout` pulse. Next grant goes to requester 1.
- Coincident release: `done[owner]` asserted in the same cycle the limit is reached → release with `timeout`=0. `done` on a non-owner bit → no effect.
- Reset mid-grant: `rst` asserted while `grant`=4'b1000 → `grant`, `bus_valid`, `timeout`=0 next edge. `ptr`=3, so requester 0 wins the next arbitration when `req`=4'b1001.
